twofish_mds_mul: RTL

- Multi-cycle Twofish MDS matrix multiplier over GF(2^8).
- Sits directly downstream of the q-permutation / key-dependent S-box stage. Consumes the four 8-bit S-box outputs y0..y3 of one g/h-function evaluation and produces the 32-bit word Z = MDS·y that feeds the PHT.
- Processes one input byte (one matrix column) per clock, with valid/ready handshakes on both sides.

---
 rtl/twofish_mds_mul_if.sv | 28 ++
 rtl/twofish_mds_mul.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/twofish_mds_mul_if.sv
// Handshake bundle between the S-box stage, the MDS multiplier and the PHT.
// The producer/consumer side uses master. The multiplier uses slave.
interface twofish_mds_mul_if;
    logic [31:0] Y;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Z;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output Y,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  Z,
        input  out_valid
    );

    modport slave (
        input  Y,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output Z,
        output out_valid
    );
endinterface

// File: rtl/twofish_mds_mul.sv
// Multi-cycle Twofish MDS multiplier over GF(2^8).
// One matrix column is folded into the accumulator per clock:
// load edge, then four column edges, then the result is held in DONE.
module twofish_mds_mul #(
    parameter logic [8:0] POLY = 9'h169
) (
    input  logic clk,
    input  logic rst,
    twofish_mds_mul_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [31:0] y_reg;
    logic [31:0] acc_reg;
    logic [31:0] z_reg;
    logic [1:0]  cnt_reg;

    logic        load;
    logic        step;
    logic        in_ready_c;
    logic        out_valid_c;
    logic [7:0]  y_sel;
    logic [31:0] prod;
    logic [31:0] acc_sum;

    // Carry-less shift-and-add multiply; the running multiplicand is reduced
    // after every shift so no 9-bit value ever reaches the accumulator.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] p;
        logic [7:0] r;
        p = {1'b0, a};
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                r = r ^ p[7:0];
            end
            p = p << 1;
            if (p[8]) begin
                p = p ^ POLY;
            end
        end
        return r;
    endfunction

    // MDS coefficient for output row `row` and input column `col`.
    function automatic logic [7:0] mds_coef(input logic [1:0] row, input logic [1:0] col);
        logic [7:0] c;
        case ({row, col})
            4'h0: c = 8'h01;  4'h1: c = 8'hEF;  4'h2: c = 8'h5B;  4'h3: c = 8'h5B;
            4'h4: c = 8'h5B;  4'h5: c = 8'hEF;  4'h6: c = 8'hEF;  4'h7: c = 8'h01;
            4'h8: c = 8'hEF;  4'h9: c = 8'h5B;  4'hA: c = 8'h01;  4'hB: c = 8'hEF;
            4'hC: c = 8'hEF;  4'hD: c = 8'h01;  4'hE: c = 8'hEF;  4'hF: c = 8'h5B;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake decode. DONE may hand off and accept on one edge.
    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load       = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pick the operand byte for the column currently being folded in.
    always_comb begin
        y_sel = 8'h00;
        case (cnt_reg)
            2'd0: y_sel = y_reg[7:0];
            2'd1: y_sel = y_reg[15:8];
            2'd2: y_sel = y_reg[23:16];
            2'd3: y_sel = y_reg[31:24];
            default: y_sel = 8'h00;
        endcase
    end

    // One constant-coefficient multiplier per output row.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign prod[gi*8 +: 8] = gf_mul(mds_coef(2'(gi), cnt_reg), y_sel);
        end
    endgenerate

    assign acc_sum = acc_reg ^ prod;

    // Operand latch, column accumulation and result capture on the last column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg   <= 32'h0;
            acc_reg <= 32'h0;
            cnt_reg <= 2'd0;
            z_reg   <= 32'h0;
        end else if (load) begin
            y_reg   <= bus.Y;
            acc_reg <= 32'h0;
            cnt_reg <= 2'd0;
        end else if (step) begin
            acc_reg <= acc_sum;
            cnt_reg <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
                z_reg <= acc_sum;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.Z         = z_reg;

endmodule
